// File: rtl/prei_mode_select.sv
// Pre-intra mode decision: scans the 32 angular-mode gradient costs one per cycle
// and reports the two largest (lowest mode wins ties), with a one-cycle done pulse.
module prei_mode_select #(
  parameter int W     = 22,
  parameter int NMODE = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [NMODE*W-1:0] cost_i,
  output logic               ready_o,
  output logic               done_o,
  output logic [5:0]         best_mode_o,
  output logic [W-1:0]       best_cost_o,
  output logic [5:0]         sec_mode_o,
  output logic [W-1:0]       sec_cost_o
);

  localparam int IW = $clog2(NMODE);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_DONE
  } state_t;

  state_t         r_state;
  state_t         w_next_state;

  logic [W-1:0]   r_cost [NMODE];
  // r_idx is the array position being scanned, i.e. mode number minus 2
  logic [IW-1:0]  r_idx;

  logic [5:0]     r_best_mode;
  logic [W-1:0]   r_best_cost;
  logic [5:0]     r_sec_mode;
  logic [W-1:0]   r_sec_cost;

  logic [5:0]     r_out_best_mode;
  logic [W-1:0]   r_out_best_cost;
  logic [5:0]     r_out_sec_mode;
  logic [W-1:0]   r_out_sec_cost;

  logic           w_accept;
  logic           w_last;
  logic [W-1:0]   w_c2;
  logic [W-1:0]   w_c3;
  logic [W-1:0]   w_cur_cost;
  logic [5:0]     w_cur_mode;

  logic [5:0]     w_nxt_best_mode;
  logic [W-1:0]   w_nxt_best_cost;
  logic [5:0]     w_nxt_sec_mode;
  logic [W-1:0]   w_nxt_sec_cost;

  assign w_accept   = (r_state == S_IDLE) && start_i;
  assign w_last     = (r_idx == IW'(NMODE - 1));
  assign w_c2       = cost_i[W-1:0];
  assign w_c3       = cost_i[2*W-1:W];
  assign w_cur_cost = r_cost[r_idx];
  assign w_cur_mode = 6'(r_idx) + 6'd2;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (start_i) w_next_state = S_SCAN;
      S_SCAN:  if (w_last)  w_next_state = S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    ready_o = (r_state == S_IDLE);
    done_o  = (r_state == S_DONE);
  end

  // Strict compares: a cost equal to an incumbent never displaces it, so the
  // earlier (lower) mode survives every tie.
  always_comb begin
    w_nxt_best_mode = r_best_mode;
    w_nxt_best_cost = r_best_cost;
    w_nxt_sec_mode  = r_sec_mode;
    w_nxt_sec_cost  = r_sec_cost;
    if (w_cur_cost > r_best_cost) begin
      w_nxt_sec_mode  = r_best_mode;
      w_nxt_sec_cost  = r_best_cost;
      w_nxt_best_mode = w_cur_mode;
      w_nxt_best_cost = w_cur_cost;
    end else if (w_cur_cost > r_sec_cost) begin
      w_nxt_sec_mode  = w_cur_mode;
      w_nxt_sec_cost  = w_cur_cost;
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      for (int k = 0; k < NMODE; k++) r_cost[k] <= cost_i[k*W +: W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx           <= '0;
      r_best_mode     <= '0;
      r_best_cost     <= '0;
      r_sec_mode      <= '0;
      r_sec_cost      <= '0;
      r_out_best_mode <= '0;
      r_out_best_cost <= '0;
      r_out_sec_mode  <= '0;
      r_out_sec_cost  <= '0;
    end else begin
      if (w_accept) begin
        r_idx <= IW'(2);
        if (w_c3 > w_c2) begin
          r_best_mode <= 6'd3;
          r_best_cost <= w_c3;
          r_sec_mode  <= 6'd2;
          r_sec_cost  <= w_c2;
        end else begin
          r_best_mode <= 6'd2;
          r_best_cost <= w_c2;
          r_sec_mode  <= 6'd3;
          r_sec_cost  <= w_c3;
        end
      end else if (r_state == S_SCAN) begin
        r_idx       <= r_idx + IW'(1);
        r_best_mode <= w_nxt_best_mode;
        r_best_cost <= w_nxt_best_cost;
        r_sec_mode  <= w_nxt_sec_mode;
        r_sec_cost  <= w_nxt_sec_cost;
        if (w_last) begin
          r_out_best_mode <= w_nxt_best_mode;
          r_out_best_cost <= w_nxt_best_cost;
          r_out_sec_mode  <= w_nxt_sec_mode;
          r_out_sec_cost  <= w_nxt_sec_cost;
        end
      end
    end
  end

  assign best_mode_o = r_out_best_mode;
  assign best_cost_o = r_out_best_cost;
  assign sec_mode_o  = r_out_sec_mode;
  assign sec_cost_o  = r_out_sec_cost;

endmodule

// File: tb/tb_prei_mode_select.sv
// Directed bench for prei_mode_select: hand-computed best/second-best results,
// latency, handshake, mid-scan reset and max-cost boundary.
module tb_prei_mode_select;

  localparam int W     = 22;
  localparam int NMODE = 32;

  logic               clk = 1'b0;
  logic               rst;
  logic               startI;
  logic [NMODE*W-1:0] costBus;
  logic               ready;
  logic               done;
  logic [5:0]         bestMode;
  logic [W-1:0]       bestCost;
  logic [5:0]         secMode;
  logic [W-1:0]       secCost;

  logic [NMODE*W-1:0] pat;
  int                 nVec = 0;
  int                 nMis = 0;
  int                 lat;
  logic               sawDone;

  prei_mode_select #(.W(W), .NMODE(NMODE)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (startI),
    .cost_i      (costBus),
    .ready_o     (ready),
    .done_o      (done),
    .best_mode_o (bestMode),
    .best_cost_o (bestCost),
    .sec_mode_o  (secMode),
    .sec_cost_o  (secCost)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [NMODE*W-1:0] bus, input logic st);
    costBus = bus;
    startI  = st;
  endtask

  task automatic setMode(input int mode, input int value);
    pat[(mode-2)*W +: W] = W'(value);
  endtask

  task automatic fillAll(input int value);
    for (int m = 2; m <= 33; m++) setMode(m, value);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nVec++;
    assert (obs === exp)
    else begin
      nMis++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic waitDone(output int cycles);
    cycles = 0;
    while (done !== 1'b1 && cycles < 100) begin
      tick();
      cycles++;
    end
  endtask

  task automatic runScan(input string tag, input int bm, input int bc, input int sm, input int sc);
    int l;
    applyStimulus(pat, 1'b1);
    tick();
    applyStimulus(pat, 1'b0);
    checkOutput({tag, "_busy"}, 32'(ready), 32'd0);
    waitDone(l);
    checkOutput({tag, "_latency"}, 32'(l), 32'd30);
    checkOutput({tag, "_bestMode"}, 32'(bestMode), 32'(bm));
    checkOutput({tag, "_bestCost"}, 32'(bestCost), 32'(bc));
    checkOutput({tag, "_secMode"}, 32'(secMode), 32'(sm));
    checkOutput({tag, "_secCost"}, 32'(secCost), 32'(sc));
    tick();
    checkOutput({tag, "_donePulse"}, 32'(done), 32'd0);
    checkOutput({tag, "_readyAgain"}, 32'(ready), 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus('0, 1'b0);
    repeat (2) tick();
    checkOutput("rst_ready", 32'(ready), 32'd1);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_bestMode", 32'(bestMode), 32'd0);
    checkOutput("rst_secMode", 32'(secMode), 32'd0);
    rst = 1'b0;
    tick();

    pat = '0;
    runScan("zero", 2, 0, 3, 0);

    for (int m = 2; m <= 33; m++) setMode(m, 100 * m);
    runScan("ramp", 33, 3300, 32, 3200);

    fillAll(1);
    setMode(18, 5000);
    setMode(10, 4000);
    runScan("peaks", 18, 5000, 10, 4000);

    fillAll(777);
    runScan("ties", 2, 777, 3, 777);

    // Start held high; cost bus scrambled every cycle of the scan.
    for (int m = 2; m <= 33; m++) setMode(m, 100 * m);
    applyStimulus(pat, 1'b1);
    tick();
    lat = 0;
    while (done !== 1'b1 && lat < 100) begin
      for (int m = 0; m < NMODE; m++) costBus[m*W +: W] = W'($urandom);
      if (lat == 10) checkOutput("hold_busy", 32'(ready), 32'd0);
      tick();
      lat++;
    end
    checkOutput("hold_latency", 32'(lat), 32'd30);
    checkOutput("hold_bestMode", 32'(bestMode), 32'd33);
    checkOutput("hold_bestCost", 32'(bestCost), 32'd3300);
    checkOutput("hold_secMode", 32'(secMode), 32'd32);
    checkOutput("hold_secCost", 32'(secCost), 32'd3200);
    fillAll(5);
    setMode(20, 123456);
    setMode(33, 123456);
    applyStimulus(pat, 1'b1);
    tick();
    checkOutput("hold_idleReady", 32'(ready), 32'd1);
    checkOutput("hold_idleDone", 32'(done), 32'd0);
    tick();
    checkOutput("hold_reaccept", 32'(ready), 32'd0);
    applyStimulus('0, 1'b0);
    repeat (5) tick();
    checkOutput("hold_keepBest", 32'(bestMode), 32'd33);
    checkOutput("hold_keepCost", 32'(bestCost), 32'd3300);
    waitDone(lat);
    checkOutput("b2b_latency", 32'(lat), 32'd25);
    checkOutput("b2b_bestMode", 32'(bestMode), 32'd20);
    checkOutput("b2b_bestCost", 32'(bestCost), 32'd123456);
    checkOutput("b2b_secMode", 32'(secMode), 32'd33);
    checkOutput("b2b_secCost", 32'(secCost), 32'd123456);
    tick();

    // Reset partway through a scan must abort it silently.
    fillAll(1);
    setMode(18, 5000);
    applyStimulus(pat, 1'b1);
    tick();
    applyStimulus(pat, 1'b0);
    repeat (15) tick();
    checkOutput("abort_busy", 32'(ready), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("abort_ready", 32'(ready), 32'd1);
    checkOutput("abort_done", 32'(done), 32'd0);
    checkOutput("abort_bestMode", 32'(bestMode), 32'd0);
    checkOutput("abort_bestCost", 32'(bestCost), 32'd0);
    checkOutput("abort_secMode", 32'(secMode), 32'd0);
    checkOutput("abort_secCost", 32'(secCost), 32'd0);
    sawDone = 1'b0;
    repeat (40) begin
      tick();
      if (done === 1'b1) sawDone = 1'b1;
    end
    checkOutput("abort_noDone", 32'(sawDone), 32'd0);

    pat = '0;
    setMode(2, 4194303);
    runScan("maxc", 2, 4194303, 3, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
